// File: rtl/sdr_batch_reader.sv
// Splits a long word fetch into SDRAM read bursts of at most MAX_NREAD words
// and streams the burst data out over a valid/ready port.
module sdr_batch_reader #(
   parameter int unsigned MAX_NREAD = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [31:0]               base_addr,
   input  logic [29:0]               nwords,
   output logic                      busy,
   output logic                      done,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_data,
   output logic                      out_last,
   output logic [31:0]               sdr_baseaddr,
   output logic [29:0]               sdr_nelems,
   output logic                      sdr_readstart,
   input  logic                      sdr_readend,
   input  logic [32*MAX_NREAD-1:0]   sdr_readdata
);

   localparam int unsigned IDX_W     = (MAX_NREAD > 1) ? $clog2(MAX_NREAD) : 1;
   localparam logic [29:0] MAX_CHUNK = 30'(MAX_NREAD);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_STREAM,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        base_q, base_d;
   logic [29:0]        words_done_q, words_done_d;
   logic [29:0]        remaining_q, remaining_d;
   logic [29:0]        chunk_q, chunk_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        out_data_q, out_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic               rdstart_q, rdstart_d;

   logic [31:0]        rd_word [MAX_NREAD];
   logic               last_word_c;

   // Unpacked view of the flat burst data bus.
   always_comb begin
      for (int i = 0; i < int'(MAX_NREAD); i++) begin
         rd_word[i] = sdr_readdata[32*i +: 32];
      end
   end

   assign last_word_c = (30'(idx_q) == (chunk_q - 30'd1));

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      words_done_d = words_done_q;
      remaining_d  = remaining_q;
      chunk_d      = chunk_q;
      idx_d        = idx_q;
      addr_d       = addr_q;
      out_data_d   = out_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d       = base_addr;
               remaining_d  = nwords;
               words_done_d = '0;
               state_d      = (nwords == 30'd0) ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (sdr_readend) begin
               state_d = ST_STREAM;
               idx_d   = '0;
            end
         end
         ST_STREAM: begin
            if (out_ready) begin
               if (last_word_c) begin
                  words_done_d = words_done_q + chunk_q;
                  remaining_d  = remaining_q - chunk_q;
                  state_d      = (remaining_d == 30'd0) ? ST_DONE : ST_REQ;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Burst parameters are latched on entry to REQ and held until the next REQ.
      if (state_d == ST_REQ) begin
         chunk_d = (remaining_d > MAX_CHUNK) ? MAX_CHUNK : remaining_d;
         addr_d  = base_d + {words_done_d, 2'b00};
      end

      // Data only advances on entry to STREAM or on an accepted transfer.
      if ((state_d == ST_STREAM) && ((state_q != ST_STREAM) || out_ready)) begin
         out_data_d = rd_word[idx_d];
      end

      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      valid_d   = (state_d == ST_STREAM);
      rdstart_d = (state_d == ST_REQ);
      last_d    = (state_d == ST_STREAM) && (30'(idx_d) == (chunk_d - 30'd1)) &&
                  (remaining_d == chunk_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         base_q       <= '0;
         words_done_q <= '0;
         remaining_q  <= '0;
         chunk_q      <= '0;
         idx_q        <= '0;
         addr_q       <= '0;
         out_data_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         valid_q      <= 1'b0;
         last_q       <= 1'b0;
         rdstart_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         words_done_q <= words_done_d;
         remaining_q  <= remaining_d;
         chunk_q      <= chunk_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         out_data_q   <= out_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         valid_q      <= valid_d;
         last_q       <= last_d;
         rdstart_q    <= rdstart_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign out_valid     = valid_q;
   assign out_data      = out_data_q;
   assign out_last      = last_q;
   assign sdr_baseaddr  = addr_q;
   assign sdr_nelems    = chunk_q;
   assign sdr_readstart = rdstart_q;

endmodule

// File: tb/tb_sdr_batch_reader.sv
// Bench for sdr_batch_reader: behavioural SDRAM read engine, randomized consumer,
// and a word/burst reference model derived from base address and word count.
module tb_sdr_batch_reader;

   localparam int MAX    = 64;
   localparam int PERIOD = 10;

   logic                  clk;
   logic                  reset;
   logic                  start;
   logic [31:0]           base_addr;
   logic [29:0]           nwords;
   logic                  busy;
   logic                  done;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           out_data;
   logic                  out_last;
   logic [31:0]           sdr_baseaddr;
   logic [29:0]           sdr_nelems;
   logic                  sdr_readstart;
   logic                  sdr_readend;
   logic [32*MAX-1:0]     sdr_readdata;

   sdr_batch_reader #(.MAX_NREAD(MAX)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .nwords        (nwords),
      .busy          (busy),
      .done          (done),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .sdr_baseaddr  (sdr_baseaddr),
      .sdr_nelems    (sdr_nelems),
      .sdr_readstart (sdr_readstart),
      .sdr_readend   (sdr_readend),
      .sdr_readdata  (sdr_readdata)
   );

   initial clk = 1'b0;
   always #(PERIOD/2) clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // knobs
   bit          fixed_mode = 1'b0;
   logic [31:0] salt       = 32'h5A17_C0DE;
   int          eng_lat    = -1;
   bit          spur_en    = 1'b0;
   int          ready_mode = 0;

   // observations
   logic [31:0] got_words[$];
   bit          got_last[$];
   time         got_time[$];
   logic [31:0] got_baddr[$];
   logic [29:0] got_bn[$];
   int          busy_cycles, valid_cycles, done_cnt, stall_viol;
   time         done_time, t_start;

   // reference model
   logic [31:0] exp_words[$];
   bit          exp_last[$];
   logic [31:0] exp_baddr[$];
   logic [29:0] exp_bn[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (fixed_mode) return 32'hA + ((a - 32'h1000) >> 2);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   function automatic void build_model(input logic [31:0] b, input int n);
      int off;
      int c;
      exp_words.delete(); exp_last.delete(); exp_baddr.delete(); exp_bn.delete();
      for (int i = 0; i < n; i++) begin
         exp_words.push_back(mem_word(b + 32'(4*i)));
         exp_last.push_back(i == n-1);
      end
      off = 0;
      while (off < n) begin
         c = (n - off > MAX) ? MAX : n - off;
         exp_baddr.push_back(b + 32'(4*off));
         exp_bn.push_back(30'(c));
         off += c;
      end
   endfunction

   function automatic int word_errs();
      int e = 0;
      if (got_words.size() != exp_words.size()) e++;
      for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
         if (got_words[i] !== exp_words[i] || got_last[i] !== exp_last[i]) e++;
      return e;
   endfunction

   function automatic int burst_errs();
      int e = 0;
      if (got_baddr.size() != exp_baddr.size()) e++;
      for (int i = 0; i < got_baddr.size() && i < exp_baddr.size(); i++)
         if (got_baddr[i] !== exp_baddr[i] || got_bn[i] !== exp_bn[i]) e++;
      return e;
   endfunction

   // SDRAM read engine model
   initial begin : engine
      bit          pend;
      int          wait_n;
      logic [31:0] e_addr;
      int          e_n;
      bit          fired;
      pend = 1'b0; wait_n = 0; e_addr = '0; e_n = 0;
      sdr_readend  = 1'b0;
      sdr_readdata = '0;
      forever begin
         @(negedge clk);
         sdr_readend = 1'b0;
         fired = 1'b0;
         if (reset) begin
            pend = 1'b0;
         end else if (pend) begin
            if (wait_n == 0) begin
               for (int i = 0; i < MAX; i++)
                  sdr_readdata[32*i +: 32] = (i < e_n) ? mem_word(e_addr + 32'(4*i)) : $urandom;
               sdr_readend = 1'b1;
               pend  = 1'b0;
               fired = 1'b1;
            end else begin
               wait_n--;
            end
         end else if (!fired && spur_en && ($urandom_range(0, 3) == 0)) begin
            sdr_readend = 1'b1;
         end
         if (!reset && sdr_readstart === 1'b1) begin
            got_baddr.push_back(sdr_baseaddr);
            got_bn.push_back(sdr_nelems);
            e_addr = sdr_baseaddr;
            e_n    = int'(sdr_nelems);
            pend   = 1'b1;
            wait_n = (eng_lat >= 0) ? eng_lat : int'($urandom_range(0, 3));
         end
      end
   end

   // consumer + monitor
   initial begin : consumer
      bit          prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      int          pat_i;
      logic [3:0]  pat;
      pat = 4'b1001;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; pat_i = 0;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: begin
               out_ready = pat[pat_i % 4];
               if (out_valid === 1'b1) pat_i++;
            end
         endcase
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
            stall_viol++;
         if (out_valid === 1'b1) valid_cycles++;
         if (out_valid === 1'b1 && out_ready) begin
            got_words.push_back(out_data);
            got_last.push_back(out_last);
            got_time.push_back($time);
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (busy === 1'b1) busy_cycles++;
         if (done === 1'b1) begin
            done_cnt++;
            done_time = $time;
         end
      end
   end

   task automatic clear_obs();
      got_words.delete(); got_last.delete(); got_time.delete();
      got_baddr.delete(); got_bn.delete();
      busy_cycles = 0; valid_cycles = 0; done_cnt = 0; stall_viol = 0;
   endtask

   task automatic run_xfer(input logic [31:0] b, input logic [29:0] n, input bit poke,
                           output bit to);
      clear_obs();
      base_addr = b; nwords = n; start = 1'b1; t_start = $time;
      @(negedge clk);
      start = 1'b0; base_addr = $urandom; nwords = 30'($urandom_range(1, 500));
      to = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         start = poke && (i == 8 || i == 40);
         @(negedge clk);
         if (done_cnt != 0) begin
            to = 1'b0;
            break;
         end
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      bit to;
      reset = 1'b1; start = 1'b0; base_addr = '0; nwords = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, out_valid, out_last, sdr_readstart, sdr_baseaddr, sdr_nelems, out_data} !== 99'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b valid=%b last=%b rs=%b addr=%h n=%0d data=%h, want all 0",
                  busy, done, out_valid, out_last, sdr_readstart, sdr_baseaddr, sdr_nelems, out_data);
      end
      fixed_mode = 1'b0; eng_lat = -1; ready_mode = 0;
      build_model(32'h0000_2000, 1);
      reset = 1'b0;
      run_xfer(32'h0000_2000, 30'd1, 1'b0, to);
      n_checks++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL start_after_reset: timed out, want done"); end
      n_checks++;
      if (word_errs() !== 0) begin
         n_fail++;
         $display("FAIL start_after_reset_words: got %0d words, want 1 word %h", got_words.size(), exp_words[0]);
      end
   endtask

   task automatic test_basic();
      bit to;
      fixed_mode = 1'b1; eng_lat = 0; ready_mode = 0;
      build_model(32'h0000_1000, 3);
      run_xfer(32'h0000_1000, 30'd3, 1'b0, to);
      n_checks++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: no done"); end
      n_checks++;
      if (burst_errs() !== 0) begin
         n_fail++;
         $display("FAIL basic_burst: got %0d bursts (first %h/%0d), want 1 burst 00001000/3",
                  got_baddr.size(), got_baddr.size() ? got_baddr[0] : 32'h0, got_bn.size() ? got_bn[0] : 30'd0);
      end
      n_checks++;
      if (word_errs() !== 0) begin
         n_fail++;
         $display("FAIL basic_words: got %0d words, want A,B,C with last on C", got_words.size());
      end
      if (got_time.size() == 3) begin
         n_checks++;
         if (got_time[0] - t_start !== 3*PERIOD) begin
            n_fail++; $display("FAIL basic_latency: got %0t, want %0d", got_time[0] - t_start, 3*PERIOD);
         end
         n_checks++;
         if (got_time[2] - got_time[0] !== 2*PERIOD) begin
            n_fail++; $display("FAIL basic_consecutive: span %0t, want %0d", got_time[2] - got_time[0], 2*PERIOD);
         end
         n_checks++;
         if (done_time - got_time[2] !== PERIOD) begin
            n_fail++; $display("FAIL basic_done_timing: got %0t after last, want %0d", done_time - got_time[2], PERIOD);
         end
      end
      n_checks++;
      if (busy_cycles !== 6 || done_cnt !== 1) begin
         n_fail++; $display("FAIL basic_busy_done: busy %0d done %0d, want 6 and 1", busy_cycles, done_cnt);
      end
      fixed_mode = 1'b0;
   endtask

   task automatic test_multi_burst();
      bit to;
      eng_lat = -1; ready_mode = 1;
      build_model(32'h0000_1000, 150);
      run_xfer(32'h0000_1000, 30'd150, 1'b0, to);
      n_checks++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL multi_timeout: no done"); end
      n_checks++;
      if (burst_errs() !== 0) begin
         n_fail++; $display("FAIL multi_bursts: got %0d bursts, want 3 (1000/64,1100/64,1200/22)", got_baddr.size());
      end
      n_checks++;
      if (word_errs() !== 0) begin
         n_fail++; $display("FAIL multi_words: got %0d words, want 150 with last only on 149", got_words.size());
      end
      n_checks++;
      if (stall_viol !== 0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL multi_stall_done: stall_viol %0d done %0d, want 0 and 1", stall_viol, done_cnt);
      end
   endtask

   task automatic test_zero();
      bit to;
      ready_mode = 0;
      run_xfer(32'h0000_1000, 30'd0, 1'b0, to);
      n_checks++;
      if (to !== 1'b0 || done_cnt !== 1) begin
         n_fail++; $display("FAIL zero_done: timeout %0b done %0d, want 0 and 1", to, done_cnt);
      end
      n_checks++;
      if (got_baddr.size() !== 0 || valid_cycles !== 0 || busy_cycles !== 1) begin
         n_fail++;
         $display("FAIL zero_quiet: bursts %0d valid %0d busy %0d, want 0 0 1", got_baddr.size(), valid_cycles, busy_cycles);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      ready_mode = 2; eng_lat = 1;
      build_model(32'h0000_4000, 10);
      run_xfer(32'h0000_4000, 30'd10, 1'b0, to);
      n_checks++;
      if (to !== 1'b0 || word_errs() !== 0) begin
         n_fail++; $display("FAIL backpressure_words: timeout %0b got %0d words, want 10 in order", to, got_words.size());
      end
      n_checks++;
      if (stall_viol !== 0) begin
         n_fail++; $display("FAIL backpressure_stable: %0d unstable stall cycles, want 0", stall_viol);
      end
      ready_mode = 0; eng_lat = -1;
   endtask

   task automatic test_reset_mid();
      bit to;
      bit seen;
      ready_mode = 0; eng_lat = 3;
      clear_obs();
      base_addr = 32'h0000_8000; nwords = 30'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = (got_baddr.size() != 0);
      end
      n_checks++;
      if (!seen || busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_wait_setup: readstart seen %0b busy %b, want 1 1", seen, busy);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, out_valid, out_last, sdr_readstart, sdr_baseaddr, sdr_nelems, out_data} !== 99'b0) begin
         n_fail++;
         $display("FAIL reset_in_wait: busy=%b valid=%b rs=%b addr=%h n=%0d data=%h, want all 0",
                  busy, out_valid, sdr_readstart, sdr_baseaddr, sdr_nelems, out_data);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      eng_lat = -1;
      clear_obs();
      base_addr = 32'h0001_0000; nwords = 30'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && got_words.size() < 5; i++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, out_valid, out_last, sdr_readstart, sdr_baseaddr, sdr_nelems, out_data} !== 99'b0) begin
         n_fail++;
         $display("FAIL reset_in_stream: busy=%b valid=%b last=%b addr=%h n=%0d data=%h, want all 0",
                  busy, out_valid, out_last, sdr_baseaddr, sdr_nelems, out_data);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      ready_mode = 1;
      build_model(32'h0002_0000, 40);
      run_xfer(32'h0002_0000, 30'd40, 1'b0, to);
      n_checks++;
      if (to !== 1'b0 || word_errs() !== 0 || burst_errs() !== 0) begin
         n_fail++;
         $display("FAIL reset_fresh_xfer: timeout %0b words %0d bursts %0d, want 0 40 1", to, got_words.size(), got_baddr.size());
      end
   endtask

   task automatic test_wrap();
      bit to;
      ready_mode = 1;
      build_model(32'hFFFF_FF00, 128);
      run_xfer(32'hFFFF_FF00, 30'd128, 1'b0, to);
      n_checks++;
      if (to !== 1'b0 || got_baddr.size() !== 2) begin
         n_fail++; $display("FAIL wrap_bursts: timeout %0b bursts %0d, want 0 2", to, got_baddr.size());
      end else begin
         n_checks++;
         if (got_baddr[1] !== 32'h0000_0000 || burst_errs() !== 0) begin
            n_fail++; $display("FAIL wrap_addr: got second addr %h, want 00000000", got_baddr[1]);
         end
      end
      n_checks++;
      if (word_errs() !== 0) begin
         n_fail++; $display("FAIL wrap_words: got %0d words, want 128", got_words.size());
      end
   endtask

   task automatic test_random_spurious();
      bit          to;
      logic [31:0] b;
      int          n;
      spur_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b = {$urandom} & 32'hFFFF_FFFC;
         n = int'($urandom_range(1, 200));
         ready_mode = int'($urandom_range(0, 2));
         salt = $urandom;
         build_model(b, n);
         run_xfer(b, 30'(n), 1'b0, to);
         n_checks++;
         if (to !== 1'b0 || word_errs() !== 0 || burst_errs() !== 0 || stall_viol !== 0) begin
            n_fail++;
            $display("FAIL random_%0d: base %h n %0d timeout %0b words %0d bursts %0d stall %0d",
                     k, b, n, to, got_words.size(), got_baddr.size(), stall_viol);
         end
      end
      spur_en = 1'b0;
   endtask

   task automatic test_start_ignored_busy();
      bit to;
      ready_mode = 1; eng_lat = -1;
      build_model(32'h0003_0000, 200);
      run_xfer(32'h0003_0000, 30'd200, 1'b1, to);
      n_checks++;
      if (to !== 1'b0 || word_errs() !== 0 || burst_errs() !== 0 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL start_while_busy: timeout %0b words %0d bursts %0d done %0d, want 0 200 4 1",
                  to, got_words.size(), got_baddr.size(), done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      ready_mode = 0;
      build_model(32'h0004_0000, 65);
      run_xfer(32'h0004_0000, 30'd65, 1'b0, to);
      n_checks++;
      if (to !== 1'b0 || word_errs() !== 0 || burst_errs() !== 0) begin
         n_fail++; $display("FAIL b2b_first: timeout %0b words %0d bursts %0d", to, got_words.size(), got_baddr.size());
      end
      build_model(32'h0005_0000, 64);
      run_xfer(32'h0005_0000, 30'd64, 1'b0, to);
      n_checks++;
      if (to !== 1'b0 || word_errs() !== 0 || burst_errs() !== 0) begin
         n_fail++; $display("FAIL b2b_second: timeout %0b words %0d bursts %0d", to, got_words.size(), got_baddr.size());
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; nwords = '0;
      test_reset();
      test_basic();
      test_multi_burst();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      test_random_spurious();
      test_start_ignored_busy();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdr_batch_reader.md
SDR_BATCH_READER -- requirements
Module: sdr_batch_reader

Interface
REQ-001 SHALL have parameter MAX_NREAD, default 64; it is the maximum number of 32-bit words per SDRAM read burst and matches the read engine's capacity.
REQ-002 SHALL have port clk, input, 1 bit; the clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit; single-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 SHALL have port base_addr, input, 32 bits; byte address of word 0; captured on an accepted start.
REQ-006 SHALL have port nwords, input, 30 bits; total 32-bit words to fetch; captured on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit; high from the cycle after an accepted start through the DONE cycle inclusive.
REQ-008 SHALL have port done, output, 1 bit; one-cycle pulse at transfer completion.
REQ-009 SHALL have port out_valid, output, 1 bit; out_data holds a valid word.
REQ-010 SHALL have port out_ready, input, 1 bit; the consumer accepts the word.
REQ-011 SHALL have port out_data, output, 32 bits; streamed word.
REQ-012 SHALL have port out_last, output, 1 bit; high with the final word of the whole transfer.
REQ-013 SHALL have port sdr_baseaddr, output, 32 bits; burst byte address to the read engine.
REQ-014 SHALL have port sdr_nelems, output, 30 bits; burst word count to the read engine.
REQ-015 SHALL have port sdr_readstart, output, 1 bit; one-cycle burst request.
REQ-016 SHALL have port sdr_readend, input, 1 bit; one-cycle burst-complete pulse.
REQ-017 SHALL have port sdr_readdata, input, 32*MAX_NREAD bits; burst data; word i is bits [32*i+31 : 32*i].

Function
REQ-018 SHALL implement the states IDLE, REQ, WAIT, STREAM and DONE.
REQ-019 In IDLE, SHALL capture base_addr and nwords when start=1; go to DONE if nwords==0, else to REQ.
REQ-020 In IDLE, SHALL ignore start while in any other state.
REQ-021 In REQ, SHALL set chunk_len = min(remaining, MAX_NREAD), assert sdr_readstart for exactly one cycle, then go to WAIT.
REQ-022 SHALL hold sdr_baseaddr = base_addr + 4*words_done and sdr_nelems = chunk_len stable from REQ until the next REQ.
REQ-023 Address arithmetic SHALL be modulo 2^32, wrapping silently.
REQ-024 In WAIT, SHALL go to STREAM on the cycle after sdr_readend=1 and reset the word index idx to 0.
REQ-025 sdr_readend SHALL be ignored in every state other than WAIT.
REQ-026 In STREAM, out_valid SHALL be 1 and out_data SHALL equal word idx of sdr_readdata.
REQ-027 out_data, out_last and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 On each STREAM cycle with out_ready=1, the word SHALL transfer and idx SHALL increment.
REQ-029 On the transfer of idx == chunk_len-1: words_done += chunk_len, remaining -= chunk_len; go to DONE if remaining==0, else to REQ.
REQ-030 out_last SHALL equal out_valid AND (idx == chunk_len-1) AND (remaining == chunk_len).
REQ-031 In DONE, done SHALL be 1 for one cycle, followed by an unconditional return to IDLE.
REQ-032 Latency from start to the first out_valid SHALL be 3 cycles plus the engine latency up to sdr_readend.
REQ-033 out_valid SHALL be 0 outside STREAM.

Reset
REQ-034 While reset=1, SHALL enter IDLE, regardless of any operation in progress.
REQ-035 During reset, busy, done, out_valid, out_last and sdr_readstart SHALL be 0, and sdr_baseaddr, sdr_nelems, out_data, idx, words_done and remaining SHALL be 0.
REQ-036 In the first cycle after reset deasserts, SHALL accept start.

Verification
REQ-037 base_addr=0x1000, nwords=3, out_ready=1, engine data {0xA,0xB,0xC} -> one readstart with addr 0x1000 and nelems 3; out_data 0xA,0xB,0xC on consecutive cycles; out_last on 0xC; done 1 cycle after.
REQ-038 nwords=150, MAX_NREAD=64 -> three bursts: (0x1000,64), (0x1100,64), (0x1200,22); 150 words; out_last only on word 149.
REQ-039 nwords=0 -> no readstart; busy high 1 cycle; done pulse; no out_valid.
REQ-040 out_ready toggles 1,0,0,1 during streaming -> no word lost or duplicated; out_data stable while stalled.
REQ-041 reset asserted in WAIT and again mid-STREAM -> next cycle IDLE with all outputs 0; a fresh start completes normally.
REQ-042 base_addr=0xFFFFFF00, nwords=128 -> second burst address 0x00000000.
